sys_support_ctl: RTL and testbench



---
 rtl/sys_support_pkg.sv | 22 ++
 rtl/sys_support_ctl_btn_debounce.sv | 37 +++
 rtl/sys_support_ctl.sv | 151 +++++++++++++++
 tb/tb_sys_support_ctl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_support_pkg.sv
// Shared state encoding and button indices for the board support/reset controller.
package sys_support_pkg;

  typedef enum logic [2:0] {
    S_DCM   = 3'd0,
    S_LPDDR = 3'd1,
    S_CALIB = 3'd2,
    S_RESET = 3'd3,
    S_BOOT  = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  localparam int BTN_RESET = 0;
  localparam int BTN_BOOT  = 1;
  localparam int BTN_HALT  = 2;
  localparam int BTN_INT   = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sys_support_ctl_btn_debounce.sv
// One-bit button debouncer: 2-flop synchroniser followed by a stability counter
// that must see 2^DEBOUNCE_W consecutive mismatching cycles before the output follows.
module btn_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db
);

  logic                  meta;
  logic                  sync;
  logic [DEBOUNCE_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      // any return to the current level restarts the window
      if (sync == db) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        db  <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_support_ctl.sv
// Board support sequencer: DCM/LPDDR/CPU reset ordering, button controls, cpu_ce divider.
// Optional calibration watchdog enabled by defining CALIB_TIMEOUT_EN.
module sys_support_ctl
  import sys_support_pkg::*;
#(
  parameter int NBTN       = 4,
  parameter int DEBOUNCE_W = 16,
  parameter int DIV_W      = 4,
  parameter int DCM_HOLD   = 64,
  parameter int LPDDR_HOLD = 32,
  parameter int RESET_HOLD = 1024,
  parameter int BOOT_HOLD  = 16,
  parameter int TMO_W      = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBTN-1:0]  button_in,
  input  logic             calib_done,
  input  logic [DIV_W-1:0] div_sel,
  output logic [NBTN-1:0]  btn_db,
  output logic             dcm_reset,
  output logic             lpddr_reset,
  output logic             sys_reset,
  output logic             boot,
  output logic             halt,
  output logic             interrupt,
  output logic             cpu_ce,
  output logic             calib_err,
  output logic [2:0]       state
);

  localparam int HOLD_MAX = max_of(max_of(DCM_HOLD, LPDDR_HOLD), max_of(RESET_HOLD, BOOT_HOLD));
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  state_t              cur_state;
  state_t              nxt_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic                calib_meta;
  logic                calib_sync;
  logic [DIV_W-1:0]    ce_cnt;
  logic                prev_reset;
  logic                prev_boot;
  logic                prev_int;
  logic                rise_reset;
  logic                rise_boot;
  logic                rise_int;
`ifdef CALIB_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_cnt;
`endif

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (button_in[i]),
      .db      (btn_db[i])
    );
  end

  assign rise_reset = btn_db[BTN_RESET] & ~prev_reset;
  assign rise_boot  = btn_db[BTN_BOOT]  & ~prev_boot;
  assign rise_int   = btn_db[BTN_INT]   & ~prev_int;
  assign state      = cur_state;

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_DCM:   if (hold_cnt == HOLD_W'(DCM_HOLD - 1))   nxt_state = S_LPDDR;
      S_LPDDR: if (hold_cnt == HOLD_W'(LPDDR_HOLD - 1)) nxt_state = S_CALIB;
      S_CALIB: begin
        if (calib_sync) nxt_state = S_RESET;
`ifdef CALIB_TIMEOUT_EN
        else if (tmo_cnt == '1) nxt_state = S_LPDDR;
`endif
      end
      S_RESET: if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) nxt_state = S_BOOT;
      S_BOOT:  if (hold_cnt == HOLD_W'(BOOT_HOLD - 1))  nxt_state = S_RUN;
      S_RUN: begin
        if (!calib_sync)                  nxt_state = S_CALIB;
        else if (rise_reset || rise_boot) nxt_state = S_RESET;
      end
      default: nxt_state = S_DCM;
    endcase
    hold_nxt = (nxt_state != cur_state) ? '0 : hold_cnt + 1'b1;
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= S_DCM;
      hold_cnt    <= '0;
      calib_meta  <= 1'b0;
      calib_sync  <= 1'b0;
      prev_reset  <= 1'b0;
      prev_boot   <= 1'b0;
      prev_int    <= 1'b0;
      dcm_reset   <= 1'b1;
      lpddr_reset <= 1'b1;
      sys_reset   <= 1'b1;
      boot        <= 1'b0;
      halt        <= 1'b0;
      interrupt   <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      hold_cnt    <= hold_nxt;
      calib_meta  <= calib_done;
      calib_sync  <= calib_meta;
      prev_reset  <= btn_db[BTN_RESET];
      prev_boot   <= btn_db[BTN_BOOT];
      prev_int    <= btn_db[BTN_INT];
      dcm_reset   <= (nxt_state == S_DCM);
      lpddr_reset <= (nxt_state == S_DCM) || (nxt_state == S_LPDDR);
      sys_reset   <= (nxt_state != S_BOOT) && (nxt_state != S_RUN);
      boot        <= (nxt_state == S_BOOT);
      halt        <= (nxt_state == S_RUN) && btn_db[BTN_HALT];
      interrupt   <= (cur_state == S_RUN) && (nxt_state == S_RUN) && rise_int;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt <= '0;
      cpu_ce <= 1'b0;
    end else if (cur_state == S_DCM) begin
      ce_cnt <= '0;
      cpu_ce <= 1'b0;
    end else if (ce_cnt >= div_sel) begin
      ce_cnt <= '0;
      cpu_ce <= 1'b1;
    end else begin
      ce_cnt <= ce_cnt + 1'b1;
      cpu_ce <= 1'b0;
    end
  end

`ifdef CALIB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt   <= '0;
      calib_err <= 1'b0;
    end else begin
      tmo_cnt   <= ((cur_state == S_CALIB) && (nxt_state == S_CALIB)) ? tmo_cnt + 1'b1 : '0;
      calib_err <= calib_err | ((cur_state == S_CALIB) && (nxt_state == S_LPDDR));
    end
  end
`else
  assign calib_err = 1'b0;
`endif

endmodule

// File: tb/tb_sys_support_ctl.sv
// Directed scoreboard bench for sys_support_ctl with reduced hold/debounce sizes.
module tb_sys_support_ctl;

  localparam int NBTN       = 4;
  localparam int DEBOUNCE_W = 4;
  localparam int DIV_W      = 4;
  localparam int DCM_HOLD   = 8;
  localparam int LPDDR_HOLD = 4;
  localparam int RESET_HOLD = 16;
  localparam int BOOT_HOLD  = 4;
  localparam int TMO_W      = 6;

  localparam int P_DCM = 0, P_LPDDR = 1, P_SYS = 2, P_BOOT = 3, P_HALT = 4;
  localparam int P_INT = 5, P_CE = 6, P_DB0 = 7, P_STATE = 8, P_ERR = 9, P_DBALL = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NBTN-1:0]  button_in;
  logic             calib_done;
  logic [DIV_W-1:0] div_sel;
  logic [NBTN-1:0]  btn_db;
  logic             dcm_reset, lpddr_reset, sys_reset, boot, halt, interrupt, cpu_ce, calib_err;
  logic [2:0]       st;

  sys_support_ctl #(
    .NBTN(NBTN), .DEBOUNCE_W(DEBOUNCE_W), .DIV_W(DIV_W), .DCM_HOLD(DCM_HOLD),
    .LPDDR_HOLD(LPDDR_HOLD), .RESET_HOLD(RESET_HOLD), .BOOT_HOLD(BOOT_HOLD), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .button_in(button_in), .calib_done(calib_done),
    .div_sel(div_sel), .btn_db(btn_db), .dcm_reset(dcm_reset), .lpddr_reset(lpddr_reset),
    .sys_reset(sys_reset), .boot(boot), .halt(halt), .interrupt(interrupt),
    .cpu_ce(cpu_ce), .calib_err(calib_err), .state(st)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      P_DCM:   return {31'd0, dcm_reset};
      P_LPDDR: return {31'd0, lpddr_reset};
      P_SYS:   return {31'd0, sys_reset};
      P_BOOT:  return {31'd0, boot};
      P_HALT:  return {31'd0, halt};
      P_INT:   return {31'd0, interrupt};
      P_CE:    return {31'd0, cpu_ce};
      P_DB0:   return {31'd0, btn_db[0]};
      P_STATE: return {29'd0, st};
      P_ERR:   return {31'd0, calib_err};
      P_DBALL: return {28'd0, btn_db};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Cycles from base until probe(sel) === val; all-ones if the budget runs out.
  task automatic wait_sig(input int sel, input logic [31:0] val, input int unsigned budget,
                          input int unsigned base, output logic [31:0] at);
    at = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i <= budget; i++) begin
      if (probe(sel) === val) begin
        at = cyc - base;
        return;
      end
      tick();
    end
  endtask

  task automatic collect8(output logic [7:0] v);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      v[i] = cpu_ce;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] at;
    logic [7:0]  v8;
    logic [12:0] v13;
    int unsigned base;
    int unsigned first;
    int unsigned cnt;

    reset_n    = 1'b0;
    button_in  = '0;
    calib_done = 1'b1;
    div_sel    = '0;
    repeat (3) tick();

    // reset state
    expect_val("rst_state", 0);     check(probe(P_STATE));
    expect_val("rst_dcm", 1);       check(probe(P_DCM));
    expect_val("rst_lpddr", 1);     check(probe(P_LPDDR));
    expect_val("rst_sys", 1);       check(probe(P_SYS));
    expect_val("rst_boot", 0);      check(probe(P_BOOT));
    expect_val("rst_halt", 0);      check(probe(P_HALT));
    expect_val("rst_int", 0);       check(probe(P_INT));
    expect_val("rst_ce", 0);        check(probe(P_CE));
    expect_val("rst_btn_db", 0);    check(probe(P_DBALL));
    expect_val("rst_calib_err", 0); check(probe(P_ERR));

    // power-up sequence, timestamps relative to reset release
    reset_n = 1'b1;
    base = cyc;
    expect_val("pu_dcm_fall", 8);
    expect_val("pu_lpddr_fall", 12);
    expect_val("pu_state_reset", 13);
    expect_val("pu_sys_fall", 29);
    expect_val("pu_boot_rise", 29);
    expect_val("pu_boot_fall", 33);
    expect_val("pu_state_run", 5);
    wait_sig(P_DCM, 0, 40, base, at);   check(at);
    wait_sig(P_LPDDR, 0, 40, base, at); check(at);
    wait_sig(P_STATE, 3, 40, base, at); check(at);
    wait_sig(P_SYS, 0, 60, base, at);   check(at);
    wait_sig(P_BOOT, 1, 60, base, at);  check(at);
    wait_sig(P_BOOT, 0, 60, base, at);  check(at);
    check(probe(P_STATE));

    // cpu_ce divider sweep
    expect_val("ce_div0", 8'hFF);
    collect8(v8); check({24'd0, v8});
    div_sel = 4'd1;
    expect_val("ce_div1", 8'hAA);
    wait_sig(P_CE, 1, 20, cyc, at);
    collect8(v8); check({24'd0, v8});
    div_sel = 4'd3;
    expect_val("ce_div3", 8'h88);
    wait_sig(P_CE, 1, 20, cyc, at);
    collect8(v8); check({24'd0, v8});
    div_sel = 4'd7;
    expect_val("ce_div7_to_2", 13'h0920);
    wait_sig(P_CE, 1, 20, cyc, at);
    v13 = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      v13[i] = cpu_ce;
      if (i == 4) div_sel = 4'd2;
    end
    check({19'd0, v13});
    div_sel = '0;

    // glitch on the reset button is ignored
    button_in[0] = 1'b1;
    repeat (10) tick();
    button_in[0] = 1'b0;
    repeat (25) tick();
    expect_val("glitch_btn_db0", 0); check(probe(P_DB0));
    expect_val("glitch_state", 5);   check(probe(P_STATE));

    // held reset button: debounce, reset and boot
    base = cyc;
    button_in[0] = 1'b1;
    expect_val("rb_db0_rise", 18);
    expect_val("rb_state_reset", 19);
    expect_val("rb_sys_rise", 19);
    expect_val("rb_sys_fall", 35);
    expect_val("rb_boot_fall", 39);
    expect_val("rb_db0_fall", 48);
    wait_sig(P_DB0, 1, 40, base, at);   check(at);
    wait_sig(P_STATE, 3, 40, base, at); check(at);
    wait_sig(P_SYS, 1, 40, base, at);   check(at);
    while (cyc - base < 30) tick();
    button_in[0] = 1'b0;
    wait_sig(P_SYS, 0, 40, base, at);   check(at);
    wait_sig(P_BOOT, 0, 40, base, at);  check(at);
    wait_sig(P_DB0, 0, 40, base, at);   check(at);

    // interrupt: one pulse on press, none on release
    base  = cyc;
    first = 32'hFFFF_FFFF;
    cnt   = 0;
    button_in[3] = 1'b1;
    expect_val("int_first", 19);
    expect_val("int_count", 1);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (interrupt === 1'b1) begin
        if (first == 32'hFFFF_FFFF) first = cyc - base;
        cnt++;
      end
      if (cyc - base == 40) button_in[3] = 1'b0;
    end
    check(first);
    check(cnt);

    // halt follows debounced button 2 while running
    base = cyc;
    button_in[2] = 1'b1;
    expect_val("halt_rise", 19);
    wait_sig(P_HALT, 1, 40, base, at); check(at);
    base = cyc;
    button_in[2] = 1'b0;
    expect_val("halt_fall", 19);
    wait_sig(P_HALT, 0, 40, base, at); check(at);

    // interrupt button pressed during reset produces no pulse
    base = cyc;
    button_in[0] = 1'b1;
    expect_val("ir_state_reset", 19);
    wait_sig(P_STATE, 3, 40, base, at); check(at);
    button_in[3] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (interrupt === 1'b1) cnt++;
      if (i == 30) button_in = '0;
    end
    expect_val("ir_int_count", 0); check(cnt);
    expect_val("ir_state_run", 5); check(probe(P_STATE));

    // calibration lost while running
    base = cyc;
    calib_done = 1'b0;
    expect_val("cal_state_calib", 3);
    expect_val("cal_sys_rise", 3);
    wait_sig(P_STATE, 2, 20, base, at); check(at);
    wait_sig(P_SYS, 1, 20, base, at);   check(at);
`ifdef CALIB_TIMEOUT_EN
    expect_val("tmo_state_lpddr", 67);
    expect_val("tmo_calib_err", 1);
    expect_val("tmo_lpddr_fall", 71);
    wait_sig(P_STATE, 1, 120, base, at); check(at);
    check(probe(P_ERR));
    wait_sig(P_LPDDR, 0, 120, base, at); check(at);
`else
    repeat (80) tick();
    expect_val("cal_wait_state", 2); check(probe(P_STATE));
    expect_val("cal_no_err", 0);     check(probe(P_ERR));
`endif

    // calibration restored: full reset and boot
    base = cyc;
    calib_done = 1'b1;
    expect_val("cal_rest_state_reset", 3);
    expect_val("cal_rest_sys_fall", 19);
    expect_val("cal_rest_boot_fall", 23);
    expect_val("cal_rest_state_run", 5);
    wait_sig(P_STATE, 3, 20, base, at); check(at);
    wait_sig(P_SYS, 0, 40, base, at);   check(at);
    wait_sig(P_BOOT, 0, 40, base, at);  check(at);
    check(probe(P_STATE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
